// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, constants and derived sizes for the TPU controller
//
// Purpose : state encoding, load-select constants and the cycle counts of the
//           clear/feed/drain schedule, all derived from the array dimension.
// Ports   : none (package).
package tpu_pkg;

  localparam int TPU_DIM = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } tpu_state_e;

  localparam logic LOAD_SEL_A = 1'b0;
  localparam logic LOAD_SEL_B = 1'b1;

  function automatic int tpu_idx_w(input int dim);
    int n;
    n = dim * dim;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tpu_feed_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int tpu_drain_cycles(input int dim);
    return dim - 1;
  endfunction

  // Counter must cover the last feed step (2*DIM-2); drain count is always smaller.
  function automatic int tpu_step_w(input int dim);
    int n;
    n = 2 * dim - 1;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TPU_IDX_W        = tpu_idx_w(TPU_DIM);
  localparam int TPU_STEP_W       = tpu_step_w(TPU_DIM);
  localparam int TPU_FEED_CYCLES  = tpu_feed_cycles(TPU_DIM);
  localparam int TPU_DRAIN_CYCLES = tpu_drain_cycles(TPU_DIM);

endpackage

// File: rtl/tpu_edge_detect.sv
// rtl/tpu_edge_detect.sv - rising-edge detector with reset-to-1 history register
//
// Purpose : flags a 0->1 transition of a level input. The history register
//           resets to 1 so a level already high during reset is not an edge.
// Ports   : i_clk   clock
//           i_rst   synchronous active-high reset
//           i_sig   level input
//           o_rise  high while i_sig is 1 and the previous sampled value was 0
module tpu_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_hist;

endmodule

// File: rtl/tpu_controller.sv
// rtl/tpu_controller.sv - load decode, operand tracking and systolic schedule FSM
//
// Purpose : turns host load edges into one-cycle write strobes, tracks which
//           A/B elements are present, runs CLEAR -> FEED -> DRAIN -> DONE once
//           both matrices are complete, and gates host result reads in DONE.
//           Optional macro TPU_WEIGHT_REUSE_EN keeps the weight bitmap across
//           DONE so only the B matrix must be reloaded.
// Ports   : i_clk, i_rst          clock, synchronous active-high reset
//           i_load_en             host load request (level, edge-triggered)
//           i_load_sel_ab         0 = weight (A), 1 = input (B)
//           i_load_index          element index of the write
//           i_output_en           host read request (level)
//           i_output_sel          result element to present
//           o_wmem_wr_en          write strobe to weight memory
//           o_imem_wr_en          write strobe to input buffer
//           o_wr_addr             write address
//           o_acc_clr             clear PE accumulators
//           o_feed_en, o_feed_step  systolic skew feed enable and step
//           o_out_sel, o_out_valid  registered result-mux select and valid
//           o_busy, o_done        schedule running / result ready
module tpu_controller
  import tpu_pkg::*;
#(
  parameter  int DIM    = TPU_DIM,
  localparam int IDX_W  = tpu_idx_w(DIM),
  localparam int STEP_W = tpu_step_w(DIM)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic              i_load_sel_ab,
  input  logic [IDX_W-1:0]  i_load_index,
  input  logic              i_output_en,
  input  logic [IDX_W-1:0]  i_output_sel,
  output logic              o_wmem_wr_en,
  output logic              o_imem_wr_en,
  output logic [IDX_W-1:0]  o_wr_addr,
  output logic              o_acc_clr,
  output logic              o_feed_en,
  output logic [STEP_W-1:0] o_feed_step,
  output logic [IDX_W-1:0]  o_out_sel,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int N_ELEM    = DIM * DIM;
  localparam int FEED_CYC  = tpu_feed_cycles(DIM);
  localparam int DRAIN_CYC = tpu_drain_cycles(DIM);
  localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(FEED_CYC - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  tpu_state_e          r_state, w_next;
  logic [STEP_W-1:0]   r_cnt, w_cnt_d;
  logic [N_ELEM-1:0]   r_bm_a, r_bm_b, w_bm_a_d, w_bm_b_d;

  logic                r_wmem_wr_en, w_wmem_wr_en_d;
  logic                r_imem_wr_en, w_imem_wr_en_d;
  logic [IDX_W-1:0]    r_wr_addr, w_wr_addr_d;
  logic                r_acc_clr, r_feed_en, r_busy, r_done;
  logic [STEP_W-1:0]   r_feed_step, w_feed_step_d;
  logic [IDX_W-1:0]    r_out_sel, w_out_sel_d;
  logic                r_out_valid, w_out_valid_d;

  logic                w_load_edge;
  logic                w_load_accept;

  tpu_edge_detect u_load_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_load_en),
    .o_rise (w_load_edge)
  );

  always_comb begin
    w_next         = r_state;
    w_cnt_d        = '0;
    w_bm_a_d       = r_bm_a;
    w_bm_b_d       = r_bm_b;
    w_wmem_wr_en_d = 1'b0;
    w_imem_wr_en_d = 1'b0;
    w_wr_addr_d    = r_wr_addr;
    w_out_sel_d    = r_out_sel;
    w_out_valid_d  = 1'b0;
    w_load_accept  = 1'b0;
    w_feed_step_d  = '0;

    case (r_state)
      ST_IDLE: begin
        // Full bitmaps are checked first; the minimum load spacing guarantees
        // no load edge coincides with this transition.
        if ((&r_bm_a) && (&r_bm_b)) begin
          w_next = ST_CLEAR;
        end else if (w_load_edge) begin
          w_load_accept = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_next = ST_FEED;
      end
      ST_FEED: begin
        if (r_cnt == FEED_LAST) begin
          w_next = (DRAIN_CYC > 0) ? ST_DRAIN : ST_DONE;
        end else begin
          w_cnt_d = r_cnt + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_next = ST_DONE;
        end else begin
          w_cnt_d = r_cnt + STEP_W'(1);
        end
      end
      ST_DONE: begin
        // A load edge beats a concurrent read: leave DONE and write at once,
        // so the strobe is seen with the block already back in IDLE.
        if (w_load_edge) begin
          w_next        = ST_IDLE;
          w_load_accept = 1'b1;
        end else if (i_output_en) begin
          w_out_sel_d   = i_output_sel;
          w_out_valid_d = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    if (w_load_accept) begin
      w_wr_addr_d = i_load_index;
      if (i_load_sel_ab == LOAD_SEL_A) begin
        w_wmem_wr_en_d         = 1'b1;
        w_bm_a_d[i_load_index] = 1'b1;
      end else begin
        w_imem_wr_en_d         = 1'b1;
        w_bm_b_d[i_load_index] = 1'b1;
      end
    end

    if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
`ifdef TPU_WEIGHT_REUSE_EN
      w_bm_a_d = r_bm_a;
`else
      w_bm_a_d = '0;
`endif
      w_bm_b_d = '0;
    end

    if (w_next == ST_FEED) begin
      w_feed_step_d = w_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bm_a       <= '0;
      r_bm_b       <= '0;
      r_wmem_wr_en <= 1'b0;
      r_imem_wr_en <= 1'b0;
      r_wr_addr    <= '0;
      r_acc_clr    <= 1'b0;
      r_feed_en    <= 1'b0;
      r_feed_step  <= '0;
      r_out_sel    <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_d;
      r_bm_a       <= w_bm_a_d;
      r_bm_b       <= w_bm_b_d;
      r_wmem_wr_en <= w_wmem_wr_en_d;
      r_imem_wr_en <= w_imem_wr_en_d;
      r_wr_addr    <= w_wr_addr_d;
      r_acc_clr    <= (w_next == ST_CLEAR);
      r_feed_en    <= (w_next == ST_FEED);
      r_feed_step  <= w_feed_step_d;
      r_out_sel    <= w_out_sel_d;
      r_out_valid  <= w_out_valid_d;
      r_busy       <= (w_next == ST_CLEAR) || (w_next == ST_FEED) || (w_next == ST_DRAIN);
      r_done       <= (w_next == ST_DONE);
    end
  end

  assign o_wmem_wr_en = r_wmem_wr_en;
  assign o_imem_wr_en = r_imem_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_acc_clr    = r_acc_clr;
  assign o_feed_en    = r_feed_en;
  assign o_feed_step  = r_feed_step;
  assign o_out_sel    = r_out_sel;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
